// File: rtl/feedback_packer.sv
// Averages per-microframe counts over 2^AVG_LOG2 SOFs into a 32-bit feedback
// word and serializes each word LSB-first over a valid/ready byte stream.
module feedback_packer #(
   parameter int unsigned COUNT_W  = 16,
   parameter int unsigned AVG_LOG2 = 3,
   parameter int unsigned FB_SHIFT = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sof_stb,
   input  logic [COUNT_W-1:0] count_in,
   output logic [31:0]        fb_value,
   output logic               fb_update,
   output logic [7:0]         byte_data,
   output logic               byte_valid,
   input  logic               byte_ready,
   output logic               byte_last,
   output logic               overrun,
   input  logic               clr_overrun
);

   localparam int unsigned ACC_W = COUNT_W + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] CNT_MAX = '1;

   // The shifted window sum must fit the 32-bit feedback word.
   generate
      if (ACC_W + FB_SHIFT > 32) begin : g_bad_cfg
         $error("feedback_packer: COUNT_W+AVG_LOG2+FB_SHIFT exceeds 32");
      end
   endgenerate

   typedef enum logic {S_IDLE, S_SEND} state_t;

   // accumulator side
   logic [ACC_W-1:0]    acc_q, acc_d, sum_c;
   logic [AVG_LOG2-1:0] cnt_q, cnt_d;
   logic                armed_q, armed_d;
   logic [31:0]         fb_value_q, fb_value_d;
   logic                fb_update_q, fb_update_d;

   // sender side
   state_t      state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
   logic        overrun_q, overrun_d;
   logic        bv_q, bv_d;
   logic [7:0]  bd_q, bd_d;
   logic        bl_q, bl_d;
   logic        load_c, ovw_c;
   logic [31:0] load_word_c;

   // Window accumulation; first SOF after enable only arms (partial frame).
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      armed_d     = armed_q;
      fb_value_d  = fb_value_q;
      fb_update_d = 1'b0;
      sum_c       = acc_q + ACC_W'(count_in);
      if (!en) begin
         acc_d   = '0;
         cnt_d   = '0;
         armed_d = 1'b0;
      end else if (sof_stb) begin
         if (!armed_q) begin
            armed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + AVG_LOG2'(1);
            if (cnt_q == CNT_MAX) begin
               fb_value_d  = 32'(sum_c) << FB_SHIFT;
               fb_update_d = 1'b1;
               acc_d       = '0;
            end else begin
               acc_d = sum_c;
            end
         end
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         fb_value_q  <= '0;
         fb_update_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         fb_value_q  <= fb_value_d;
         fb_update_q <= fb_update_d;
      end
   end

   // Sender next state: word load, byte stepping, pending slot and overrun.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      idx_d       = idx_q;
      pend_d      = pend_q;
      pend_vld_d  = pend_vld_q;
      bv_d        = bv_q;
      bd_d        = bd_q;
      bl_d        = bl_q;
      load_c      = 1'b0;
      load_word_c = '0;
      ovw_c       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fb_update_q) begin
               load_c      = 1'b1;
               load_word_c = fb_value_q;
            end else if (pend_vld_q) begin
               load_c      = 1'b1;
               load_word_c = pend_q;
               pend_vld_d  = 1'b0;
            end
         end
         S_SEND: begin
            // A word finishing mid-send parks in the pending slot.
            if (fb_update_q) begin
               pend_d     = fb_value_q;
               pend_vld_d = 1'b1;
               ovw_c      = pend_vld_q;
            end
            if (bv_q && byte_ready) begin
               if (idx_q == 2'd3) begin
                  if (pend_vld_q) begin
                     // Pending slot drains into the sender, so a new word
                     // arriving now takes its place without overrun.
                     load_c      = 1'b1;
                     load_word_c = pend_q;
                     pend_vld_d  = fb_update_q;
                     ovw_c       = 1'b0;
                  end else if (fb_update_q) begin
                     load_c      = 1'b1;
                     load_word_c = fb_value_q;
                     pend_vld_d  = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     bv_d    = 1'b0;
                     bd_d    = '0;
                     bl_d    = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + 2'd1;
                  bd_d  = 8'(word_q >> {idx_d, 3'b000});
                  bl_d  = (idx_d == 2'd3);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load_c) begin
         state_d = S_SEND;
         word_d  = load_word_c;
         idx_d   = '0;
         bv_d    = 1'b1;
         bd_d    = load_word_c[7:0];
         bl_d    = 1'b0;
      end
      overrun_d = overrun_q;
      if (clr_overrun) overrun_d = 1'b0;
      if (ovw_c)       overrun_d = 1'b1;
   end

   // Sender state register; reset drops any word in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         overrun_q  <= 1'b0;
         bv_q       <= 1'b0;
         bd_q       <= '0;
         bl_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         overrun_q  <= overrun_d;
         bv_q       <= bv_d;
         bd_q       <= bd_d;
         bl_q       <= bl_d;
      end
   end

   assign fb_value   = fb_value_q;
   assign fb_update  = fb_update_q;
   assign byte_data  = bd_q;
   assign byte_valid = bv_q;
   assign byte_last  = bl_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_feedback_packer.sv
// Bench for feedback_packer: word-level reference model checked every cycle,
// plus directed scenarios with hand-computed words and byte sequences.
module tb_feedback_packer;

   localparam int unsigned COUNT_W  = 16;
   localparam int unsigned AVG_LOG2 = 3;
   localparam int unsigned FB_SHIFT = 13;

   logic               clk = 1'b0;
   logic               rst, en, sof_stb, byte_ready, clr_overrun;
   logic [COUNT_W-1:0] count_in;
   logic [31:0]        fb_value;
   logic               fb_update, byte_valid, byte_last, overrun;
   logic [7:0]         byte_data;

   feedback_packer #(.COUNT_W(COUNT_W), .AVG_LOG2(AVG_LOG2), .FB_SHIFT(FB_SHIFT)) dut (
      .clk(clk), .rst(rst), .en(en), .sof_stb(sof_stb), .count_in(count_in),
      .fb_value(fb_value), .fb_update(fb_update), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
   endtask

   // Reference model: window averaging plus one in-flight word and one pending slot.
   logic [31:0] m_fbv, m_inf, m_pend, m_sh;
   bit          m_upd, m_armed, m_inf_v, m_pend_v, m_ov, m_ovw;
   int          m_acc, m_n, m_k;

   always @(posedge clk) begin
      if (rst) begin
         m_fbv = 0; m_upd = 0; m_acc = 0; m_n = 0; m_armed = 0;
         m_inf_v = 0; m_pend_v = 0; m_k = 0; m_ov = 0; m_inf = 0; m_pend = 0;
      end else begin
         m_ovw = 0;
         if (m_inf_v && byte_ready) begin
            if (m_k == 3) begin
               m_inf_v = 0;
               if (m_pend_v) begin
                  m_inf = m_pend; m_inf_v = 1; m_pend_v = 0; m_k = 0;
               end
            end else m_k++;
         end
         if (m_upd) begin
            if (!m_inf_v) begin
               m_inf = m_fbv; m_inf_v = 1; m_k = 0;
            end else begin
               if (m_pend_v) m_ovw = 1;
               m_pend = m_fbv; m_pend_v = 1;
            end
         end
         if (m_ovw) m_ov = 1;
         else if (clr_overrun) m_ov = 0;
         m_upd = 0;
         if (!en) begin
            m_armed = 0; m_acc = 0; m_n = 0;
         end else if (sof_stb) begin
            if (!m_armed) m_armed = 1;
            else begin
               m_acc += int'(count_in);
               m_n++;
               if (m_n == (1 << AVG_LOG2)) begin
                  m_fbv = 32'(m_acc) << FB_SHIFT;
                  m_upd = 1; m_acc = 0; m_n = 0;
               end
            end
         end
      end
      #1;
      check("model fb_update", 32'(fb_update), 32'(m_upd));
      check("model fb_value", fb_value, m_fbv);
      check("model byte_valid", 32'(byte_valid), 32'(m_inf_v));
      check("model overrun", 32'(overrun), 32'(m_ov));
      if (m_inf_v) begin
         m_sh = m_inf >> (8 * m_k);
         check("model byte_data", 32'(byte_data), 32'(m_sh[7:0]));
         check("model byte_last", 32'(byte_last), 32'(m_k == 3));
      end
   end

   // Transfer/update log, sampled mid-cycle after the inputs settle.
   logic [8:0]  obs[$];
   int          upd_cnt;
   logic [31:0] last_fb;

   always @(negedge clk) begin
      #2;
      if (rst === 1'b0 && byte_valid === 1'b1 && byte_ready === 1'b1)
         obs.push_back({byte_last, byte_data});
      if (rst === 1'b0 && fb_update === 1'b1) begin
         upd_cnt++;
         last_fb = fb_value;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [COUNT_W-1:0] v);
      sof_stb = 1'b1; count_in = v;
      tick();
      sof_stb = 1'b0;
      tick();
   endtask

   task automatic window(input logic [COUNT_W-1:0] v);
      for (int i = 0; i < 8; i++) pulse(v);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 64 && byte_valid !== 1'b1; i++) tick();
      check(name, 32'(byte_valid), 32'd1);
   endtask

   task automatic check_obs(input string name, input logic [31:0] w, input int base);
      logic [8:0]  got;
      logic [31:0] sh;
      for (int k = 0; k < 4; k++) begin
         got = (base + k < obs.size()) ? obs[base + k] : 9'bx;
         sh  = w >> (8 * k);
         check(name, 32'(got), 32'({(k == 3), sh[7:0]}));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 1'b0; sof_stb = 1'b0; count_in = '0;
      byte_ready = 1'b0; clr_overrun = 1'b0;
      upd_cnt = 0; last_fb = '0;
      tick(2);
      rst = 1'b0;
      tick();
      check("reset fb_value", fb_value, 32'h0);
      check("reset byte_valid", 32'(byte_valid), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset fb_update", 32'(fb_update), 32'd0);

      // Basic window: 9 pulses of 6144, first only arms.
      byte_ready = 1'b1; en = 1'b1; obs.delete(); upd_cnt = 0;
      tick();
      repeat (9) pulse(16'd6144);
      tick(10);
      check("basic update count", 32'(upd_cnt), 32'd1);
      check("basic fb_value", last_fb, 32'h1800_0000);
      check("basic byte count", 32'(obs.size()), 32'd4);
      check_obs("basic bytes", 32'h1800_0000, 0);

      // Backpressure on the second byte.
      byte_ready = 1'b0; obs.delete();
      window(16'd6144);
      wait_valid("stall valid");
      byte_ready = 1'b1;
      tick();
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall byte_valid held", 32'(byte_valid), 32'd1);
         check("stall byte_data held", 32'(byte_data), 32'h00);
         check("stall byte_last held", 32'(byte_last), 32'd0);
         tick();
      end
      byte_ready = 1'b1;
      tick(6);
      check("stall byte count", 32'(obs.size()), 32'd4);
      check_obs("stall bytes", 32'h1800_0000, 0);

      // Overrun: three windows with the consumer blocked.
      byte_ready = 1'b0; obs.delete();
      window(16'd100); window(16'd200); window(16'd300);
      tick(2);
      check("overrun set", 32'(overrun), 32'd1);
      byte_ready = 1'b1;
      tick(12);
      check("overrun byte count", 32'(obs.size()), 32'd8);
      check_obs("overrun word1", 32'h0064_0000, 0);
      check_obs("overrun word3", 32'h012C_0000, 4);
      check("overrun drained", 32'(byte_valid), 32'd0);

      // clr_overrun alone, then coincident with an overwrite.
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check("clr alone", 32'(overrun), 32'd0);
      byte_ready = 1'b0;
      window(16'd11); window(16'd22);
      repeat (7) pulse(16'd33);
      sof_stb = 1'b1; count_in = 16'd33;
      tick();
      sof_stb = 1'b0; clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check("clr with overwrite", 32'(overrun), 32'd1);
      tick();
      check("overrun sticky", 32'(overrun), 32'd1);
      obs.delete(); byte_ready = 1'b1;
      tick(12);
      check("clr byte count", 32'(obs.size()), 32'd8);
      check_obs("clr word A", 32'h000B_0000, 0);
      check_obs("clr word C", 32'h0021_0000, 4);

      // Gating: partial window discarded, then re-arm and 8 fresh samples.
      obs.delete(); upd_cnt = 0;
      repeat (4) pulse(16'd5000);
      en = 1'b0;
      tick();
      pulse(16'd7777);
      tick(2);
      en = 1'b1;
      tick();
      pulse(16'd9999);
      for (int i = 0; i < 8; i++) pulse(16'(6000 + i));
      tick(10);
      check("gate update count", 32'(upd_cnt), 32'd1);
      check("gate fb_value", last_fb, 32'h1773_8000);
      check("gate byte count", 32'(obs.size()), 32'd4);
      check_obs("gate bytes", 32'h1773_8000, 0);

      // Reset after the first byte of a word.
      byte_ready = 1'b0;
      window(16'd6144);
      wait_valid("reset-mid valid");
      byte_ready = 1'b1;
      tick();
      byte_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst byte_valid", 32'(byte_valid), 32'd0);
      check("rst byte_data", 32'(byte_data), 32'd0);
      check("rst byte_last", 32'(byte_last), 32'd0);
      check("rst fb_value", fb_value, 32'd0);
      check("rst fb_update", 32'(fb_update), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      obs.delete(); byte_ready = 1'b1;
      tick(10);
      check("rst no stale bytes", 32'(obs.size()), 32'd0);
      check("rst idle", 32'(byte_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/feedback_packer.md
FEEDBACK_PACKER -- requirements
Module: feedback_packer

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the per-microframe count input.
REQ-002 SHALL have parameter AVG_LOG2, default 3: averaging window of 2^AVG_LOG2 SOFs.
REQ-003 SHALL have parameter FB_SHIFT, default 13: left shift applied to the window sum; COUNT_W+AVG_LOG2+FB_SHIFT SHALL be <= 32 (elaboration error otherwise).
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port en, input, 1: enables accumulation; low discards the partial window.
REQ-007 SHALL have port sof_stb, input, 1: one-cycle pulse, coincident with the cycle the upstream counter clears.
REQ-008 SHALL have port count_in, input, COUNT_W: completed count of the previous microframe, valid while sof_stb=1.
REQ-009 SHALL have port fb_value, output, 32: last completed feedback word.
REQ-010 SHALL have port fb_update, output, 1: one-cycle pulse when fb_value changes.
REQ-011 SHALL have port byte_data, output, 8: serialized feedback byte.
REQ-012 SHALL have port byte_valid, output, 1: byte_data valid.
REQ-013 SHALL have port byte_ready, input, 1: consumer accepts the byte.
REQ-014 SHALL have port byte_last, output, 1: high with the 4th byte of a word.
REQ-015 SHALL have port overrun, output, 1: sticky flag, a pending word was overwritten.
REQ-016 SHALL have port clr_overrun, input, 1: clears overrun.

Function
REQ-017 Accumulator width COUNT_W+AVG_LOG2 SHALL never overflow; sample counter AVG_LOG2 bits wide.
REQ-018 Gating: sof_stb while en=0 SHALL be ignored. en=0 SHALL clear the accumulator, the sample counter and the armed flag in the next cycle.
REQ-019 Arming: the first sof_stb after en rises SHALL only set armed and SHALL NOT be accumulated, because it covers a partial frame.
REQ-020 When armed and sof_stb=1, count_in SHALL be added to the accumulator and the sample counter SHALL increment.
REQ-021 When the sample counter wraps from 2^AVG_LOG2-1 to 0, the cycle after the final sof_stb SHALL: load fb_value = zero-extend(sum) << FB_SHIFT, pulse fb_update, and restart the accumulator at 0 (the final sample is included in the sum).
REQ-022 Consecutive sof_stb pulses on adjacent cycles SHALL each be accumulated.
REQ-023 Sender FSM states SHALL be IDLE and SEND. IDLE -> SEND when a word is available (new or pending). SEND -> IDLE after byte 3 is accepted with no pending word; SEND -> SEND (reload) after byte 3 is accepted with a pending word present.
REQ-024 In SEND, bytes SHALL be sent LSB first (bits 7:0, 15:8, 23:16, 31:24), with byte_last=1 on the fourth byte only.
REQ-025 A byte SHALL transfer when byte_valid & byte_ready; byte_data/byte_last SHALL be held stable while byte_valid=1 and byte_ready=0.
REQ-026 byte_valid SHALL be asserted no later than the cycle after fb_update when IDLE; no combinational path from byte_ready to byte_valid.
REQ-027 A word completing during SEND SHALL go to a one-entry pending register; if the pending register is already full, it SHALL be overwritten and overrun set.
REQ-028 If clr_overrun and a new overrun occur in the same cycle, overrun SHALL remain 1.
REQ-029 en=0 SHALL NOT abort a word in flight; the sender SHALL finish the current word and any pending word.

Reset
REQ-030 rst=1 at a clk edge SHALL force: fb_value=0, fb_update=0, byte_valid=0, byte_last=0, byte_data=0, overrun=0, FSM=IDLE, pending empty, accumulator=0, sample counter=0, armed=0.
REQ-031 rst SHALL take priority over all inputs; rst mid-word SHALL drop the word without completing it.

Verification
REQ-032 With AVG_LOG2=3 and FB_SHIFT=13: en=1, then 9 sof_stb pulses with count_in=6144 (the first is discarded) and byte_ready=1 -> fb_value=0x18000000, one fb_update pulse, bytes 00,00,00,18, byte_last on the 4th byte.
REQ-033 Backpressure: byte_ready=0 for 5 cycles on byte 2 -> byte_data stays 0x00 with valid held, then completes in order.
REQ-034 Overrun: byte_ready=0 throughout while 3 windows complete -> overrun=1, pending holds the 3rd word; after byte_ready=1, word 1 is sent, then word 3.
REQ-035 Gating: en drops after 4 samples, then re-arms -> the next fb_value reflects only 8 fresh samples (values 6000..6007 -> sum 48028, word 0x17738000).
REQ-036 Reset mid-SEND after byte 1 -> byte_valid=0 and all outputs zero the next cycle; no stale bytes after reset.
REQ-037 clr_overrun coincident with a new overwrite -> overrun stays 1; clr_overrun alone -> overrun=0 the next cycle.
